// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219-compatible display receiver:
// register addresses, receiver state encoding and Code-B segment patterns.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOOP   = 4'h0;
    localparam logic [3:0] ADDR_DIG1   = 4'h1;
    localparam logic [3:0] ADDR_DIG2   = 4'h2;
    localparam logic [3:0] ADDR_DIG3   = 4'h3;
    localparam logic [3:0] ADDR_DIG4   = 4'h4;
    localparam logic [3:0] ADDR_DIG5   = 4'h5;
    localparam logic [3:0] ADDR_DIG6   = 4'h6;
    localparam logic [3:0] ADDR_DIG7   = 4'h7;
    localparam logic [3:0] ADDR_DIG8   = 4'h8;
    localparam logic [3:0] ADDR_DECODE = 4'h9;
    localparam logic [3:0] ADDR_INTENS = 4'hA;
    localparam logic [3:0] ADDR_SCAN   = 4'hB;
    localparam logic [3:0] ADDR_SHDN   = 4'hC;
    localparam logic [3:0] ADDR_TEST   = 4'hF;

    typedef enum logic [1:0] {StIdle, StShift, StLatch} rx_state_e;

    // Segment order a..g, a in bit 6.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_DASH  = 7'h01;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_H     = 7'h37;
    localparam logic [6:0] SEG_L     = 7'h0E;
    localparam logic [6:0] SEG_P     = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/max7219_receiver_if.sv
// 3-wire SPI display link: the stopwatch drives it, the receiver listens.
interface max7219_receiver_if;
    logic spi_cs;
    logic spi_sck;
    logic spi_mosi;

    modport master (output spi_cs, output spi_sck, output spi_mosi);
    modport slave  (input spi_cs, input spi_sck, input spi_mosi);
endinterface

// File: rtl/code_b_decoder.sv
// Combinational MAX7219 Code-B font: 4-bit code to 7-segment a..g.
module code_b_decoder
    import max7219_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (code_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_DASH;
            4'hB: seg_o = SEG_E;
            4'hC: seg_o = SEG_H;
            4'hD: seg_o = SEG_L;
            4'hE: seg_o = SEG_P;
            4'hF: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/max7219_receiver.sv
// SPI display-side receiver: oversamples the link, latches 16-bit frames on Cs rise,
// keeps a MAX7219-style register file and drives the selected digit's segments.
module max7219_receiver
    import max7219_pkg::*;
(
    input  logic                     clk,
    input  logic                     res,
    max7219_receiver_if.slave        spi_bus,
    input  logic [2:0]               dig_sel,
    output logic [7:0]               seg_out,
    output logic [15:0]              word_out,
    output logic                     word_valid,
    output logic                     frame_err,
    output logic [7:0]               decode_mode,
    output logic [3:0]               intensity,
    output logic [2:0]               scan_limit,
    output logic                     shutdown_n,
    output logic                     display_test
);

    // Synchronizers run free through reset so a Cs held low across reset is not a fall.
    logic [2:0] cs_sync_q, sck_sync_q;
    logic [1:0] mosi_sync_q;

    always_ff @(posedge clk) begin
        cs_sync_q   <= {cs_sync_q[1:0], spi_bus.spi_cs};
        sck_sync_q  <= {sck_sync_q[1:0], spi_bus.spi_sck};
        mosi_sync_q <= {mosi_sync_q[0], spi_bus.spi_mosi};
    end

    logic cs_rise, cs_fall, sck_rise;
    assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];

    rx_state_e   state_q;
    logic [15:0] shift_q, word_out_q;
    logic [4:0]  cnt_q;
    logic        word_valid_q, frame_err_q;
    logic [7:0]  dig_q [8];
    logic [7:0]  decode_q;
    logic [3:0]  intens_q;
    logic [2:0]  scan_q;
    logic        shdn_n_q, test_q;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            cnt_q        <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            dig_q        <= '{default: 8'h00};
            decode_q     <= '0;
            intens_q     <= '0;
            scan_q       <= '0;
            shdn_n_q     <= 1'b0;
            test_q       <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q <= StShift;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                StShift: begin
                    if (cs_rise) begin
                        state_q <= StLatch;
                    end else if (sck_rise) begin
                        shift_q <= {shift_q[14:0], mosi_sync_q[1]};
                        if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
                    end
                end
                StLatch: begin
                    state_q <= StIdle;
                    if (cnt_q >= 5'd16) begin
                        word_out_q   <= shift_q;
                        word_valid_q <= 1'b1;
                        unique case (shift_q[11:8])
                            ADDR_DIG1, ADDR_DIG2, ADDR_DIG3, ADDR_DIG4,
                            ADDR_DIG5, ADDR_DIG6, ADDR_DIG7, ADDR_DIG8:
                                dig_q[3'(shift_q[11:8] - ADDR_DIG1)] <= shift_q[7:0];
                            ADDR_DECODE: decode_q <= shift_q[7:0];
                            ADDR_INTENS: intens_q <= shift_q[3:0];
                            ADDR_SCAN:   scan_q   <= shift_q[2:0];
                            ADDR_SHDN:   shdn_n_q <= shift_q[0];
                            ADDR_TEST:   test_q   <= shift_q[0];
                            ADDR_NOOP:   ;
                            default:     ;
                        endcase
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [7:0] sel_dig;
    logic [6:0] cb_seg;
    logic [7:0] seg_d, seg_q;

    assign sel_dig = dig_q[dig_sel];

    code_b_decoder u_code_b (
        .code_i (sel_dig[3:0]),
        .seg_o  (cb_seg)
    );

    always_comb begin
        seg_d = 8'h00;
        if (test_q) begin
            seg_d = 8'hFF;
        end else if (!shdn_n_q || (dig_sel > scan_q)) begin
            seg_d = 8'h00;
        end else if (decode_q[dig_sel]) begin
            seg_d = {sel_dig[7], cb_seg};
        end else begin
            seg_d = sel_dig;
        end
    end

    always_ff @(posedge clk) begin
        if (res) seg_q <= 8'h00;
        else     seg_q <= seg_d;
    end

    assign seg_out      = seg_q;
    assign word_out     = word_out_q;
    assign word_valid   = word_valid_q;
    assign frame_err    = frame_err_q;
    assign decode_mode  = decode_q;
    assign intensity    = intens_q;
    assign scan_limit   = scan_q;
    assign shutdown_n   = shdn_n_q;
    assign display_test = test_q;

endmodule

// File: tb/tb_max7219_receiver.sv
// Self-checking bench for max7219_receiver: directed frames plus random frames
// compared against a register-file model of the display.
module tb_max7219_receiver;

    logic        clk = 1'b0;
    logic        res;
    logic [2:0]  dig_sel;
    logic [7:0]  seg_out;
    logic [15:0] word_out;
    logic        word_valid, frame_err;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n, display_test;

    always #5 clk = ~clk;

    max7219_receiver_if bus ();

    max7219_receiver dut (
        .clk          (clk),
        .res          (res),
        .spi_bus      (bus.slave),
        .dig_sel      (dig_sel),
        .seg_out      (seg_out),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .frame_err    (frame_err),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown_n   (shutdown_n),
        .display_test (display_test)
    );

    int tests = 0;
    int fails = 0;

    // Display model
    logic [7:0]  m_dig [8];
    logic [7:0]  m_decode;
    logic [3:0]  m_intens;
    logic [2:0]  m_scan;
    logic        m_shdn, m_test;
    logic [15:0] m_word;
    logic [6:0]  cb_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
        m_decode = 8'h00; m_intens = 4'h0; m_scan = 3'd0;
        m_shdn = 1'b0; m_test = 1'b0; m_word = 16'h0000;
    endtask

    task automatic m_apply(input logic [15:0] w);
        int a = int'(w[11:8]);
        logic [7:0] d = w[7:0];
        m_word = w;
        if (a >= 1 && a <= 8) m_dig[a-1] = d;
        else if (a == 9)  m_decode = d;
        else if (a == 10) m_intens = d[3:0];
        else if (a == 11) m_scan = d[2:0];
        else if (a == 12) m_shdn = d[0];
        else if (a == 15) m_test = d[0];
    endtask

    function automatic logic [7:0] m_seg(input int s);
        logic [7:0] d = m_dig[s];
        if (m_test) return 8'hFF;
        if (!m_shdn) return 8'h00;
        if (s > int'(m_scan)) return 8'h00;
        if (m_decode[s]) return {d[7], cb_tab[d[3:0]]};
        return d;
    endfunction

    task automatic check_regs();
        check("word_out", 32'(word_out), 32'(m_word));
        check("decode_mode", 32'(decode_mode), 32'(m_decode));
        check("intensity", 32'(intensity), 32'(m_intens));
        check("scan_limit", 32'(scan_limit), 32'(m_scan));
        check("shutdown_n", 32'(shutdown_n), 32'(m_shdn));
        check("display_test", 32'(display_test), 32'(m_test));
    endtask

    task automatic check_seg(input int s);
        dig_sel = 3'(s);
        @(negedge clk);
        check($sformatf("seg_out[%0d]", s), 32'(seg_out), 32'(m_seg(s)));
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_mosi = bits[i];
            bus.spi_sck  = 1'b0;
            repeat (2) @(negedge clk);
            bus.spi_sck  = 1'b1;
            repeat (2) @(negedge clk);
        end
        bus.spi_sck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Counts pulses over the 10 negedges after Cs rise and records the first hit.
    task automatic observe(output int nv, output int ne, output int fv, output int fe);
        nv = 0; ne = 0; fv = -1; fe = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (word_valid) begin nv++; if (fv < 0) fv = i; end
            if (frame_err)  begin ne++; if (fe < 0) fe = i; end
        end
    endtask

    // late_sck raises Sck together with Cs; that extra bit must be dropped.
    task automatic run_frame(input logic [31:0] bits, input int n, input bit late_sck);
        int nv, ne, fv, fe;
        bus.spi_cs = 1'b0;
        repeat (3) @(negedge clk);
        shift_bits(bits, n);
        bus.spi_cs = 1'b1;
        if (late_sck) begin
            bus.spi_mosi = ~bits[0];
            bus.spi_sck  = 1'b1;
        end
        observe(nv, ne, fv, fe);
        bus.spi_sck = 1'b0;
        if (n >= 16) begin
            m_apply(bits[15:0]);
            check("valid_count", nv, 1);
            check("valid_latency", fv, 4);
            check("err_count", ne, 0);
        end else begin
            check("err_count", ne, 1);
            check("err_latency", fe, 4);
            check("valid_count", nv, 0);
        end
        check_regs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nv, ne, fv, fe, n;
        logic [31:0] bits;

        res = 1'b1; dig_sel = 3'd0;
        bus.spi_cs = 1'b1; bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0;
        m_reset();
        repeat (5) @(negedge clk);
        check("valid_in_reset", 32'(word_valid), 0);
        res = 1'b0;
        repeat (2) @(negedge clk);
        check("valid_after_reset", 32'(word_valid), 0);
        check("err_after_reset", 32'(frame_err), 0);
        check_regs();
        for (int s = 0; s < 8; s++) check_seg(s);

        // Stopwatch init sequence
        run_frame(32'h0C01, 16, 1'b0);
        run_frame(32'h093F, 16, 1'b0);
        run_frame(32'h0B0E, 16, 1'b0);
        check("init_shdn", 32'(shutdown_n), 1);
        check("init_decode", 32'(decode_mode), 32'h3F);
        check("init_scan", 32'(scan_limit), 6);

        run_frame(32'h0385, 16, 1'b0);
        check_seg(2);
        check("seg_5dp", 32'(seg_out), 32'hDB);
        run_frame(32'h0F01, 16, 1'b0);
        check_seg(5);
        check("seg_test", 32'(seg_out), 32'hFF);
        run_frame(32'h0F00, 16, 1'b0);
        for (int s = 0; s < 8; s++) check_seg(s);

        // Short frame rejected, long frame keeps the last 16 bits
        run_frame(32'h0000_0A3C, 12, 1'b0);
        run_frame(32'h0005_0A07, 20, 1'b0);
        check("long_intens", 32'(intensity), 7);

        // Reset in the middle of a frame with Cs held low
        bus.spi_cs = 1'b0;
        repeat (3) @(negedge clk);
        shift_bits(32'h0000_00A5, 8);
        res = 1'b1;
        repeat (2) @(negedge clk);
        check("err_in_reset", 32'(frame_err), 0);
        res = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        bus.spi_cs = 1'b1;
        observe(nv, ne, fv, fe);
        check("rst_valid_count", nv, 0);
        check("rst_err_count", ne, 0);
        check_regs();
        run_frame(32'h0C01, 16, 1'b0);

        // Sck rising with Cs rise is not shifted
        run_frame(32'h0B07, 16, 1'b1);
        run_frame(32'h0A5D, 16, 1'b1);
        check("late_sck_word", 32'(word_out), 32'h0A5D);

        for (int k = 0; k < 40; k++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : 16;
            bits = $urandom();
            if (bits[11:8] == 4'hF && $urandom_range(0, 2) != 0) bits[0] = 1'b0;
            run_frame(bits, n, 1'(k % 5 == 0));
            check_seg(int'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
